// File: rtl/fifo_serial_pkg.sv
// ============================================================================
// Module      : fifo_serial_pkg
// Description : Shared types and constants for the FIFO serial reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

    localparam int   FRAME_CNT_W = 16;
    localparam logic TX_IDLE     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_serial_reader_bit_timer.sv
// ============================================================================
// Module      : bit_timer
// Description : Free-running bit-period counter with a last-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o     = (cnt_q == LAST);
    // Lets the parent register outputs that must line up with the next tick.
    assign pre_tick_o = !clear_i && (cnt_q == PRE_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_serial_reader.sv
// ============================================================================
// Module      : fifo_serial_reader
// Description : Drains a FIFO one word at a time into LSB-first serial frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_serial_reader
    import fifo_serial_pkg::*;
#(
    parameter int DATO_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   fifo_empty_i,
    input  logic [DATO_WIDTH-1:0]  fifo_data_i,
    output logic                   fifo_rd_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam int IDX_W = (DATO_WIDTH > 1) ? $clog2(DATO_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATO_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_e                  state_q, state_d;
    logic [DATO_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    stop_q, stop_d;
    logic                    tx_q, tx_d;
    logic                    rd_q, rd_d;
    logic                    done_q, done_d;
    logic [FRAME_CNT_W-1:0]  cnt_q, cnt_d;

    logic w_tick;
    logic w_pre_tick;
    logic w_timer_clear;

    assign w_timer_clear = (state_q == WAIT);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (w_timer_clear),
        .tick_o     (w_tick),
        .pre_tick_o (w_pre_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        case (state_q)
            IDLE: begin
                if (en_i && !fifo_empty_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                shift_d = fifo_data_i;
                idx_d   = '0;
                stop_d  = 1'b0;
                state_d = START;
            end
            START: begin
                if (w_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (stop_q == LAST_STOP) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        rd_d = (state_d == REQ);
        tx_d = TX_IDLE;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
        done_d = (state_d == STOP) && (stop_d == LAST_STOP) && w_pre_tick;
        cnt_d  = done_d ? cnt_q + FRAME_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= TX_IDLE;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_rd_o   = rd_q;
    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign frame_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_serial_reader.sv
// ============================================================================
// Module      : tb_fifo_serial_reader
// Description : Self-checking bench for fifo_serial_reader against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_serial_reader;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int L1 = (1 + W + 1) * C;
    localparam int L2 = (1 + W + 2) * C;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd, tx, busy, done;
    logic [15:0] frame_cnt;

    logic        en2, empty2;
    logic [7:0]  data2;
    logic        rd2, tx2, busy2, done2;
    logic [15:0] cnt2;

    fifo_serial_reader #(.DATO_WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .en_i(en), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_rd_o(fifo_rd), .tx_o(tx),
        .busy_o(busy), .done_o(done), .frame_cnt_o(frame_cnt)
    );

    fifo_serial_reader #(.DATO_WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en_i(en2), .fifo_empty_i(empty2),
        .fifo_data_i(data2), .fifo_rd_o(rd2), .tx_o(tx2),
        .busy_o(busy2), .done_o(done2), .frame_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cur   = 0;

    logic [7:0] fq[$];
    logic [7:0] mq[$];
    bit         m_active = 0;
    bit         m_rst    = 0;
    int         m_start  = 0;
    logic [7:0] m_word   = 8'h00;
    int         m_cnt    = 0;
    int         rd_seen  = 0;

    bit         p2_on = 0;
    int         p2_t0 = 0;
    int         p2_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cur, obs, exp);
        end
    endtask

    // Line level of a frame at offset o cycles after the start bit begins.
    function automatic logic exp_tx(input logic [7:0] w, input int o);
        int b;
        b = o / C;
        if (b == 0) return 1'b0;
        if (b <= W) return w[b-1];
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        mq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic step();
        int   off, off2;
        logic e_tx, e_rd, e_busy, e_done;
        m_rst = rst;
        if (!rst && !m_active && en && !fifo_empty && mq.size() > 0) begin
            m_active = 1;
            m_start  = cur;
            m_word   = mq.pop_front();
        end
        @(posedge clk);
        #1;
        cur++;
        if (m_rst) begin
            m_active = 0;
            m_cnt    = 0;
        end
        off = cur - m_start;
        if (m_active && off > 2 + L1) m_active = 0;
        e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_active) begin
            e_rd   = (off == 1);
            e_busy = 1'b1;
            e_done = (off == 2 + L1);
            if (off >= 3) e_tx = exp_tx(m_word, off - 3);
        end
        if (e_done) m_cnt = (m_cnt + 1) % 65536;
        chk("tx",        32'(tx),        32'(e_tx));
        chk("fifo_rd",   32'(fifo_rd),   32'(e_rd));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("done",      32'(done),      32'(e_done));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        if (fifo_rd === 1'b1) begin
            rd_seen++;
            if (fq.size() > 0) fifo_data = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);

        if (p2_on) begin
            off2 = cur - p2_t0;
            chk("tx2",   32'(tx2),   32'((off2 >= 3 && off2 <= 2 + L2) ? exp_tx(8'h55, off2 - 3) : 1'b1));
            chk("rd2",   32'(rd2),   32'(off2 == 1));
            chk("done2", 32'(done2), 32'(off2 == 2 + L2));
            if (done2 === 1'b1) p2_done++;
            if (rd2 === 1'b1) empty2 = 1'b1;
        end
    endtask

    task automatic run_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!m_active && (mq.size() == 0 || !en)) break;
            step();
        end
        step();
        step();
    endtask

    initial begin
        int base;
        rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
        en2 = 1'b0; empty2 = 1'b1; data2 = 8'h00;
        step();
        step();
        rst = 1'b0;
        step();

        // Single 0xA5 frame
        base = rd_seen;
        push(8'hA5);
        en = 1'b1;
        run_idle(200);
        chk("single_rd_count", 32'(rd_seen - base), 32'd1);
        chk("single_frame_cnt", 32'(frame_cnt), 32'd1);

        // Three queued words back to back
        base = rd_seen;
        push(8'h00); push(8'hFF); push(8'h3C);
        run_idle(500);
        chk("three_rd_count", 32'(rd_seen - base), 32'd3);
        chk("three_frame_cnt", 32'(frame_cnt), 32'd4);

        // Empty FIFO with enable held high
        base = rd_seen;
        for (int i = 0; i < 100; i++) step();
        chk("empty_no_rd", 32'(rd_seen - base), 32'd0);

        // Enable dropped in the middle of the data bits of 0x81
        base = rd_seen;
        push(8'h81); push(8'h42);
        for (int i = 0; i < 15; i++) step();
        en = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("en_drop_rd_count", 32'(rd_seen - base), 32'd1);
        chk("en_drop_frame_cnt", 32'(frame_cnt), 32'd5);
        en = 1'b1;
        run_idle(200);
        chk("en_resume_frame_cnt", 32'(frame_cnt), 32'd6);

        // Reset in cycle 20 of a frame
        push(8'($urandom));
        for (int i = 0; i < 10 && !m_active; i++) step();
        for (int i = 0; i < 100 && cur < m_start + 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        push(8'($urandom));
        run_idle(200);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Randomized pushes, enable toggles and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0 && fq.size() < 4) push(8'($urandom));
            if ($urandom_range(0, 19) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        en  = 1'b1;
        run_idle(1000);

        // Two stop bits, word 0x55, on the second instance
        en = 1'b0;
        step();
        data2 = 8'h55; en2 = 1'b1; empty2 = 1'b0;
        p2_t0 = cur;
        p2_on = 1;
        for (int i = 0; i < 52; i++) step();
        p2_on = 0;
        chk("stop2_done_count", 32'(p2_done), 32'd1);
        chk("stop2_frame_cnt", 32'(cnt2), 32'd1);
        chk("stop2_busy_after", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
